i2c_master: RTL and testbench

I2C_MASTER -- requirements
Module: i2c_master

---
 rtl/i2c_master.sv | 127 ++++++++++++
 tb/tb_i2c_master.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// i2c_master: register-oriented I2C master issuing single-byte writes and repeated-start reads,
// with open-drain pad controls and slave clock stretching.
module i2c_master #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ack_err,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       sda_out
);
    typedef enum logic [2:0] {IDLE, START, SHIFT, ACK, RSTART, READ, MNACK, STOP} state_t;
    state_t     r_state, w_next;
    logic [7:0] r_div, r_sh, r_reg, r_wdata, r_rdata;
    logic [6:0] r_dev;
    logic [1:0] r_q, r_idx;
    logic [2:0] r_bit;
    logic       r_rw, r_nack, r_rd_ok, r_done, r_ack_err;
    logic       w_accept, w_hold, w_tick, w_smp, w_end;

    assign busy     = r_state != IDLE;
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign ack_err  = r_ack_err;
    assign w_accept = !busy && start;
    // a released SCL that the pad still reads low is a slave stretching the clock
    assign w_hold   = scl_out && !scl_in;
    assign w_tick   = busy && !w_hold && r_div == 8'(DIV - 1);
    assign w_smp    = w_tick && r_q == 2'd2;
    assign w_end    = w_tick && r_q == 2'd3;

    always_comb begin
        scl_out = 1'b1;
        sda_out = 1'b1;
        case (r_state)
            START:            sda_out = !r_q[1];
            SHIFT:            begin scl_out = r_q[1]; sda_out = r_sh[7]; end
            ACK, READ, MNACK: scl_out = r_q[1];
            RSTART:           begin scl_out = r_q != 2'd0; sda_out = !r_q[1]; end
            STOP:             begin scl_out = r_q != 2'd0; sda_out = r_q[1]; end
            default:          ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:          if (start) w_next = START;
            START, RSTART: if (w_end) w_next = SHIFT;
            SHIFT:         if (w_end && r_bit == 3'd7) w_next = ACK;
            ACK:           if (w_end) w_next = r_nack || r_idx == 2'd2 ? STOP
                                             : r_idx == 2'd3 ? READ
                                             : r_idx == 2'd1 && r_rw ? RSTART : SHIFT;
            READ:          if (w_end && r_bit == 3'd7) w_next = MNACK;
            MNACK:         if (w_end) w_next = STOP;
            STOP:          if (w_end) w_next = IDLE;
            default:       w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    // r_idx tracks the byte in flight: 0 dev+W, 1 reg, 2 wdata, 3 dev+R
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_sh      <= '0;
            r_reg     <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_dev     <= '0;
            r_q       <= '0;
            r_idx     <= '0;
            r_bit     <= '0;
            r_rw      <= 1'b0;
            r_nack    <= 1'b0;
            r_rd_ok   <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_rw      <= rw;
                r_dev     <= dev_addr;
                r_reg     <= reg_addr;
                r_wdata   <= wdata;
                r_sh      <= {dev_addr, 1'b0};
                r_idx     <= '0;
                r_bit     <= '0;
                r_div     <= '0;
                r_q       <= '0;
                r_ack_err <= 1'b0;
                r_rd_ok   <= 1'b0;
            end else if (busy) begin
                if (!w_hold) r_div <= w_tick ? 8'd0 : r_div + 8'd1;
                if (w_tick) r_q <= r_q + 2'd1;
                if (w_smp && r_state == ACK) r_nack <= sda_in;
                if (w_smp && r_state == READ) r_sh <= {r_sh[6:0], sda_in};
                if (w_end) begin
                    case (r_state)
                        SHIFT:   begin r_sh <= {r_sh[6:0], 1'b0}; r_bit <= r_bit + 3'd1; end
                        READ:    r_bit <= r_bit + 3'd1;
                        ACK:     if (r_nack) r_ack_err <= 1'b1;
                                 else if (r_idx == 2'd0) begin r_sh <= r_reg; r_idx <= 2'd1; end
                                 else if (r_idx == 2'd1 && !r_rw) begin r_sh <= r_wdata; r_idx <= 2'd2; end
                        RSTART:  begin r_sh <= {r_dev, 1'b1}; r_idx <= 2'd3; end
                        MNACK:   r_rd_ok <= 1'b1;
                        STOP:    begin r_done <= 1'b1; if (r_rd_ok) r_rdata <= r_sh; end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: drives register transactions against a behavioural I2C slave on the
// open-drain bus and compares decoded bus events, timing and status against expectations.
module tb_i2c_master;
    localparam int DIV = 4;
    localparam logic [6:0] SLV = 7'h50;
    localparam logic [15:0] EV_S = 16'h1000;
    localparam logic [15:0] EV_P = 16'h2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, ack_err, scl_out, sda_out;
    logic [7:0] rdata;
    logic       scl_bus, sda_bus;

    logic       s_sda = 1'b1;
    logic       stretch = 1'b0;
    logic       slv_rst = 1'b0;
    logic [7:0] rdval = '0;
    int         stretch_tok = 0;
    int         stretch_used = 0;
    int         n_done = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_rdata = '0;
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    assign scl_bus = scl_out & ~stretch;
    assign sda_bus = sda_out & s_sda;

    i2c_master #(.DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .dev_addr(dev_addr),
        .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .ack_err(ack_err), .scl_in(scl_bus), .sda_in(sda_bus), .scl_out(scl_out), .sda_out(sda_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) n_done++;

    function automatic logic [15:0] ev(input logic [7:0] b, input logic a);
        return {4'h3, 3'd0, a, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // behavioural slave: ACKs address SLV, ACKs every written byte, returns rdval on reads
    logic p_scl = 1'b1, p_sda = 1'b1, tx_mode = 1'b0, pend = 1'b0;
    logic [7:0] rx = '0, lb = '0;
    int bc = 0, nb = 0;
    always @(negedge clk) begin
        if (slv_rst) begin
            bc = 0; tx_mode = 1'b0; pend = 1'b0; s_sda = 1'b1;
        end else if (p_scl && scl_bus && p_sda && !sda_bus) begin
            obs_q.push_back(EV_S);
            bc = 0; nb = 0; tx_mode = 1'b0; pend = 1'b0; s_sda = 1'b1;
        end else if (p_scl && scl_bus && !p_sda && sda_bus) begin
            obs_q.push_back(EV_P);
            bc = 0; tx_mode = 1'b0; s_sda = 1'b1;
        end else if (!p_scl && scl_bus) begin
            rx = {rx[6:0], sda_bus};
            bc++;
            if (bc == 8) lb = rx;
            if (bc == 9) obs_q.push_back(ev(lb, sda_bus));
        end else if (p_scl && !scl_bus) begin
            if (bc == 8) begin
                if (tx_mode || (nb == 0 && lb[7:1] != SLV)) s_sda = 1'b1;
                else begin
                    s_sda = 1'b0;
                    if (nb == 0 && lb[0]) pend = 1'b1;
                end
            end else if (bc == 9) begin
                bc = 0; nb++;
                tx_mode = pend; pend = 1'b0;
                s_sda = tx_mode ? rdval[7] : 1'b1;
            end else if (bc >= 1 && bc <= 7 && tx_mode) s_sda = rdval[7-bc];
        end
        p_scl = scl_bus;
        p_sda = sda_bus;
    end

    always @(posedge scl_out) if (stretch_tok != stretch_used) begin
        stretch_used = stretch_tok;
        stretch = 1'b1;
        repeat (20) @(posedge clk);
        #1 stretch = 1'b0;
    end

    task automatic xfer(input logic r, input logic [6:0] d, input logic [7:0] ra, input logic [7:0] wd,
                        input logic [7:0] rv, input logic str, input int poke);
        logic nack;
        int len, exp_len, nd0;
        logic [15:0] e, o;
        nack = d != SLV;
        exp_q.push_back(EV_S);
        exp_q.push_back(ev({d, 1'b0}, nack));
        if (!nack) begin
            exp_q.push_back(ev(ra, 1'b0));
            if (r) begin
                exp_q.push_back(EV_S);
                exp_q.push_back(ev({d, 1'b1}, 1'b0));
                exp_q.push_back(ev(rv, 1'b1));
            end else exp_q.push_back(ev(wd, 1'b0));
        end
        exp_q.push_back(EV_P);
        exp_len = (nack ? 44 : r ? 156 : 116) * DIV + (str ? 20 : 0);
        if (r && !nack) exp_rdata = rv;
        @(negedge clk);
        start = 1'b1; rw = r; dev_addr = d; reg_addr = ra; wdata = wd; rdval = rv;
        if (str) stretch_tok++;
        nd0 = n_done;
        @(negedge clk);
        start = 1'b0;
        check("busy_up", busy, 1);
        check("ack_clr", ack_err, 0);
        len = 1;
        for (int i = 0; i < 5000; i++) begin
            if (poke != 0 && len == poke) begin start = 1'b1; wdata = ~wd; end
            else start = 1'b0;
            @(negedge clk);
            if (done) break;
            if (busy) len++;
        end
        start = 1'b0;
        wdata = wd;
        check("done", done, 1);
        check("busy_len", len, exp_len);
        check("ack_err", ack_err, nack);
        check("rdata", rdata, exp_rdata);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle", busy, 0);
        check("n_done", n_done - nd0, 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.size() != 0 ? obs_q.pop_front() : 16'hFFFF;
            check("bus_event", o, e);
        end
        check("extra_events", obs_q.size(), 0);
        obs_q.delete();
    endtask

    initial begin
        #1;
        check("rst_scl", scl_out, 1);
        check("rst_sda", sda_out, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_rdata", rdata, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        xfer(1'b0, 7'h50, 8'h00, 8'hA5, 8'h00, 1'b0, 0);
        xfer(1'b1, 7'h50, 8'h01, 8'h00, 8'h3C, 1'b0, 0);
        xfer(1'b0, 7'h51, 8'h00, 8'h11, 8'h00, 1'b0, 0);
        xfer(1'b0, 7'h50, 8'h12, 8'h5A, 8'h00, 1'b1, 0);

        @(negedge clk);
        start = 1'b1; rw = 1'b0; dev_addr = 7'h50; reg_addr = 8'h77; wdata = 8'h99;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        slv_rst = 1'b1;
        #1;
        check("abort_scl", scl_out, 1);
        check("abort_sda", sda_out, 1);
        check("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("abort_rdata", rdata, 0);
        rst_n = 1'b1;
        slv_rst = 1'b0;
        exp_rdata = '0;
        @(negedge clk);
        obs_q.delete();

        xfer(1'b0, 7'h50, 8'h34, 8'hC3, 8'h00, 1'b0, 0);
        xfer(1'b0, 7'h50, 8'h07, 8'h81, 8'h00, 1'b0, 40);
        xfer(1'b1, 7'h50, 8'hFF, 8'h00, 8'hF0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
